// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: reset PC default,
// instruction size, fetch FSM state encodings and the fetch-entry record
// carried from IF into the IF/OF pipeline register.
package if_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSN_BYTES       = 32'd4;

  typedef enum logic [0:0] {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Small synchronous fetch buffer with push/pop/flush, an occupancy count and
// a head that is read straight from the storage flops (no bypass: a push into
// an empty buffer becomes visible on the following cycle).
module fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic          head_valid,
  output fetch_entry_t  head_data
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_pop;
  logic            do_push;

  // Pops only ever remove real entries; a push at full is legal only alongside a pop.
  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count < CW'(DEPTH)) | do_pop);

  // Storage, pointers and count; flush empties the buffer and wins over push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_valid = (count != '0);
  assign head_data  = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the architectural PC, issues word requests to
// instruction memory under a credit scheme that reserves a buffer slot for
// every kept response, discards in-flight responses after a redirect and
// presents {Instruction, PC_Current} to operand fetch over valid/ready.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        IsBranchTaken,
  input  logic [31:0] BranchPC,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] Instruction,
  output logic [31:0] PC_Current
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

  fetch_state_e   state;
  fetch_state_e   state_next;
  logic [31:0]    fetch_pc;
  logic [31:0]    resp_pc;
  logic [OCW-1:0] outstanding;
  logic [OCW-1:0] drop_cnt;
  logic [FCW-1:0] fifo_count;
  logic           fifo_head_valid;
  fetch_entry_t   fifo_head;
  fetch_entry_t   fifo_push_data;
  logic           grant;
  logic           keep;
  logic           pop;
  logic [31:0]    occupancy;
  logic [31:0]    target;

  assign target = word_align(BranchPC);
  assign grant  = imem_req & imem_gnt;
  // A response is kept only when no stale words remain and no redirect is flushing.
  assign keep   = imem_rvalid & (drop_cnt == '0) & ~IsBranchTaken;
  // A pop coinciding with a redirect is ignored (the buffer is flushed anyway).
  assign pop    = inst_valid & inst_ready & ~IsBranchTaken;

  // Slots already spoken for: buffered words plus kept responses still in flight.
  // The slot freed by a pop this cycle is re-usable immediately, which is what
  // allows one instruction per cycle with a two-entry buffer.
  assign occupancy = 32'(fifo_count) - 32'(pop) + 32'(outstanding) - 32'(drop_cnt);

  // State register: one idle boot cycle after reset, then run forever.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = S_BOOT;
    case (state)
      S_BOOT:  state_next = S_RUN;
      S_RUN:   state_next = S_RUN;
      default: state_next = S_BOOT;
    endcase
  end

  // Request output: only in run state, never in a redirect cycle, and only with credit.
  always_comb begin
    imem_req = 1'b0;
    if ((state == S_RUN) && !IsBranchTaken &&
        (outstanding < OCW'(MAX_OUTSTANDING)) &&
        (occupancy < 32'(FIFO_DEPTH))) begin
      imem_req = 1'b1;
    end else begin
      imem_req = 1'b0;
    end
  end

  // PC tracking, outstanding-request count and stale-response drop count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      // Responses still retire even in a redirect cycle; grants cannot occur then.
      case ({grant, imem_rvalid})
        2'b10:   outstanding <= outstanding + OCW'(1);
        2'b01:   outstanding <= outstanding - OCW'(1);
        default: outstanding <= outstanding;
      endcase
      if (IsBranchTaken) begin
        fetch_pc <= target;
        resp_pc  <= target;
        drop_cnt <= outstanding - OCW'(imem_rvalid);
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + INSN_BYTES;
        end
        if (keep) begin
          resp_pc <= resp_pc + INSN_BYTES;
        end
        if (imem_rvalid && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - OCW'(1);
        end
      end
    end
  end

  assign fifo_push_data.pc   = resp_pc;
  assign fifo_push_data.insn = imem_rdata;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (FCW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (IsBranchTaken),
    .push       (keep),
    .push_data  (fifo_push_data),
    .pop        (pop),
    .count      (fifo_count),
    .head_valid (fifo_head_valid),
    .head_data  (fifo_head)
  );

  assign imem_addr   = fetch_pc;
  assign inst_valid  = fifo_head_valid;
  assign Instruction = fifo_head.insn;
  assign PC_Current  = fifo_head.pc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: an in-order instruction memory with programmable
// latency, and a stream-level reference (sequential PCs from the last
// redirect target or reset PC, word = mem(pc)).
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam int          DEPTH   = 2;
  localparam int          MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        IsBranchTaken;
  logic [31:0] BranchPC;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] Instruction;
  logic [31:0] PC_Current;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .RESET_PC        (RST_PC),
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .IsBranchTaken (IsBranchTaken),
    .BranchPC      (BranchPC),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .Instruction   (Instruction),
    .PC_Current    (PC_Current)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mq[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          outst = 0;
  int          max_outst = 0;
  int          delivered = 0;
  int          rdy_pct = 100;
  int          gnt_pct = 100;
  int          lat_lo = 1;
  int          lat_hi = 1;
  bit          saw_gap = 0;
  bit          prev_br = 0;
  logic [31:0] exp_fetch;
  logic [31:0] exp_deliver;

  function automatic logic [31:0] memf(input logic [31:0] addr);
    return addr ^ 32'hC0DE_5A00;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: starts and ends at a falling edge.
  task automatic step(input logic br, input logic [31:0] tgt);
    logic        granted;
    logic        rv;
    logic        popped;
    logic [31:0] a;
    req_t        r;
    if (prev_br) check("flush_valid", 32'(inst_valid), 32'd0);
    inst_ready    = ($urandom_range(99) < rdy_pct);
    imem_gnt      = ($urandom_range(99) < gnt_pct);
    IsBranchTaken = br;
    BranchPC      = tgt;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    granted = imem_req & imem_gnt;
    rv      = imem_rvalid;
    popped  = inst_valid & inst_ready & ~br;
    a       = imem_addr;
    check("addr_align", 32'(imem_addr[1:0]), 32'd0);
    if (br) check("req_masked", 32'(imem_req), 32'd0);
    if (granted) check("fetch_addr", imem_addr, exp_fetch);
    if (popped) begin
      check("pc", PC_Current, exp_deliver);
      check("insn", Instruction, memf(exp_deliver));
      exp_deliver += 32'd4;
      delivered++;
    end
    if (!imem_req && inst_ready && !br) saw_gap = 1'b1;
    @(posedge clk);
    if (rv) begin
      mq.delete(0);
      outst--;
    end
    if (granted) begin
      r.addr = a;
      r.due  = cyc + $urandom_range(lat_hi, lat_lo);
      mq.push_back(r);
      outst++;
    end
    cyc++;
    if (br) begin
      exp_fetch   = {tgt[31:2], 2'b00};
      exp_deliver = exp_fetch;
    end else if (granted) begin
      exp_fetch += 32'd4;
    end
    if (outst > max_outst) max_outst = outst;
    check("outst_bound", 32'(outst <= MAX_OUT), 32'd1);
    prev_br = br;
    @(negedge clk);
  endtask

  // Release reset at a falling edge and check the idle boot cycle.
  task automatic release_reset();
    imem_rvalid   = 1'b0;
    IsBranchTaken = 1'b0;
    inst_ready    = 1'b1;
    imem_gnt      = 1'b1;
    mq.delete();
    outst       = 0;
    prev_br     = 1'b0;
    exp_fetch   = RST_PC;
    exp_deliver = RST_PC;
    reset       = 1'b0;
    #1;
    check("boot_noreq", 32'(imem_req), 32'd0);
    check("boot_addr", imem_addr, RST_PC);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(imem_req),   32'd0);
    check({tag, "_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_insn"},  Instruction,     32'd0);
    check({tag, "_pc"},    PC_Current,      32'd0);
    check({tag, "_addr"},  imem_addr,       RST_PC);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int lat_cnt;
    int d0;
    reset         = 1'b1;
    imem_gnt      = 1'b0;
    imem_rvalid   = 1'b0;
    imem_rdata    = 32'd0;
    IsBranchTaken = 1'b0;
    BranchPC      = 32'd0;
    inst_ready    = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);

    // Sequential fetch from RESET_PC at full rate with a 1-cycle memory.
    release_reset();
    delivered = 0;
    rdy_pct = 100; gnt_pct = 100; lat_lo = 1; lat_hi = 1;
    repeat (8) step(1'b0, 32'd0);
    check("throughput", 32'(delivered), 32'd6);

    // Backpressure: buffer fills, requests stop; release drains in order.
    rdy_pct = 0;
    repeat (10) step(1'b0, 32'd0);
    #1;
    check("bp_noreq", 32'(imem_req), 32'd0);
    check("bp_valid", 32'(inst_valid), 32'd1);
    @(negedge clk);
    rdy_pct = 100;
    repeat (6) step(1'b0, 32'd0);

    // 3-cycle memory: bounded outstanding and request gaps.
    lat_lo = 3; lat_hi = 3; max_outst = 0; saw_gap = 1'b0;
    repeat (30) step(1'b0, 32'd0);
    check("max_outst", 32'(max_outst), 32'(MAX_OUT));
    check("req_gap", 32'(saw_gap), 32'd1);

    // Redirect with two requests in flight: both stale words discarded.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (outst == 2) found = 1'b1;
      else step(1'b0, 32'd0);
    end
    check("two_outst", 32'(found), 32'd1);
    step(1'b1, 32'h0000_0100);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (inst_valid) found = 1'b1;
      else step(1'b0, 32'd0);
    end
    check("redir_found", 32'(found), 32'd1);
    check("redir_pc", PC_Current, 32'h0000_0100);
    check("redir_insn", Instruction, memf(32'h0000_0100));

    // Redirect coinciding with rvalid and a pop; low bits of target ignored.
    lat_lo = 1; lat_hi = 1;
    repeat (6) step(1'b0, 32'd0);
    check("coinc_pre", 32'(inst_valid && mq.size() > 0 && mq[0].due <= cyc), 32'd1);
    step(1'b1, 32'h0000_0203);
    lat_cnt = 1;
    while (!inst_valid && lat_cnt < 10) begin
      step(1'b0, 32'd0);
      lat_cnt++;
    end
    check("redir_latency", 32'(lat_cnt), 32'd3);
    check("coinc_pc", PC_Current, 32'h0000_0200);
    repeat (5) step(1'b0, 32'd0);

    // Back-to-back redirects: the last target wins.
    step(1'b1, 32'h0000_0400);
    step(1'b1, 32'h0000_0500);
    repeat (8) step(1'b0, 32'd0);

    // Randomized traffic, latency, grants, backpressure and redirects.
    d0 = delivered;
    rdy_pct = 70; gnt_pct = 75; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(99) < 4) step(1'b1, $urandom);
      else step(1'b0, 32'd0);
    end
    check("random_progress", 32'(delivered > d0 + 50), 32'd1);

    // Asynchronous reset mid-stream, then restart at RESET_PC.
    rdy_pct = 0; gnt_pct = 100; lat_lo = 3; lat_hi = 3;
    repeat (4) step(1'b0, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    imem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    release_reset();
    rdy_pct = 100; lat_lo = 1; lat_hi = 1;
    delivered = 0;
    repeat (8) step(1'b0, 32'd0);
    check("restart_count", 32'(delivered), 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
